inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 clk  input  1  is the single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  is the asynchronous, active-low reset.
REQ-004 stall  input  1  is asserted by the downstream stage to hold the current instruction.
REQ-005 branch_taken  input  1  is the beq outcome for the issued instruction.
REQ-006 branch_imm  input  16  is the beq immediate field of the issued instruction.
REQ-007 jump  input  1  marks the issued instruction as j.
REQ-008 jump_addr  input  26  is the j target field of the issued instruction.
REQ-009 imem_req  output  1  is the instruction-memory read request.
REQ-010 imem_addr  output  32  is the byte address of the requested word.
REQ-011 imem_ready  input  1  is asserted when imem_rdata is valid.
REQ-012 imem_rdata  input  32  is the instruction word returned by memory.
REQ-013 inst  output  32  is the registered instruction word sent to the decoder.
REQ-014 inst_valid  output  1  marks inst as valid for consumption.
REQ-015 pc  output  32  is the address of the instruction in inst.
REQ-016 inst_count  output  32  is the count of consumed instructions.

Function
REQ-017 The FSM SHALL have states FETCH, WAIT and ISSUE.
REQ-018 In FETCH and WAIT, imem_req SHALL be 1 and imem_addr SHALL equal pc; in ISSUE, imem_req SHALL be 0.
REQ-019 In FETCH, imem_ready=1 SHALL capture imem_rdata into inst and go to ISSUE; imem_ready=0 SHALL go to WAIT.
REQ-020 WAIT SHALL hold the request until imem_ready=1, then capture and go to ISSUE; imem_rdata SHALL be ignored when imem_ready=0.
REQ-021 Minimum latency SHALL be one cycle: ready in the FETCH cycle gives inst_valid=1 on the next cycle.
REQ-022 inst_valid SHALL be 1 only in ISSUE; an instruction is consumed when inst_valid=1 and stall=0.
REQ-023 While stalled in ISSUE, inst, pc and inst_count SHALL hold, and the redirect inputs SHALL be ignored.
REQ-024 On consumption, pc SHALL load next_pc, inst_count SHALL increment by 1, and the FSM SHALL return to FETCH.
REQ-025 next_pc priority SHALL be jump, then branch_taken, then sequential; jump and branch_taken together SHALL select the jump.
REQ-026 Sequential next_pc SHALL be pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-027 Branch target SHALL be pc+4 plus sign-extended branch_imm shifted left 2, modulo 2^32.
REQ-028 Jump target SHALL be {pc_plus4[31:28], jump_addr, 2'b00}.
REQ-029 pc[1:0] SHALL always be 2'b00.
REQ-030 inst_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-031 stall while not in ISSUE SHALL have no effect.

Reset
REQ-032 rst_n=0 SHALL immediately force the FSM to FETCH, pc to RESET_PC, inst to 0, inst_valid to 0 and inst_count to 0, from any state including WAIT.
REQ-033 After rst_n deasserts, the first rising edge SHALL be treated as a FETCH cycle at RESET_PC.
REQ-034 A memory response arriving during reset SHALL be discarded.

Structure
REQ-035 The FSM state encoding and the opcode constants for beq (6'b000100) and j (6'b000010) SHALL live in the shared package mips_pkg.
REQ-036 next_pc computation SHALL be a combinational sub-module named pc_next, with inputs pc, jump, jump_addr, branch_taken and branch_imm, and output next_pc.

Verification
REQ-037 Zero-wait memory, no stall, from reset: imem_addr SHALL be 0x0, 0x4, 0x8; inst_valid SHALL be 1 on every second cycle; inst_count SHALL be 3 after the third consumption.
REQ-038 imem_ready delayed 3 cycles at pc=0x10: imem_req SHALL hold with imem_addr=0x10 for 4 cycles, and inst_valid SHALL be 1 on the cycle after ready.
REQ-039 stall=1 for 5 cycles in ISSUE: inst, pc and inst_count SHALL be unchanged and imem_req SHALL be 0; release SHALL fetch pc+4.
REQ-040 branch_taken=1, branch_imm=16'hFFFF at pc=0x20: next imem_addr SHALL be 0x20; with jump=1 and jump_addr=26'h0000040 asserted together at pc=0x20, next imem_addr SHALL be 0x100.
REQ-041 rst_n=0 in WAIT at pc=0x40 with imem_ready=1 arriving during reset: after release, imem_addr SHALL be RESET_PC, inst_count SHALL be 0, and no stale inst SHALL issue.
REQ-042 pc=0xFFFF_FFFC consumed sequentially: next imem_addr SHALL be 0x0.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch FSM encoding and MIPS opcode constants
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } fetch_state_e;

  localparam logic [5:0]  OPC_BEQ = 6'b000100;
  localparam logic [5:0]  OPC_J   = 6'b000010;
  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - combinational next-PC selection (jump > branch > sequential)
module pc_next
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        jump,
  input  logic [25:0] jump_addr,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  output logic [31:0] next_pc
);

  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_off;

  assign w_pc_plus4   = pc + PC_STEP;
  // Word offset: sign-extend the immediate and scale to bytes.
  assign w_branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

  // Jump wins over a simultaneous taken branch; sums wrap modulo 2^32.
  always_comb begin
    next_pc = w_pc_plus4;
    if (jump) begin
      next_pc = {w_pc_plus4[31:28], jump_addr, 2'b00};
    end else if (branch_taken) begin
      next_pc = w_pc_plus4 + w_branch_off;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: memory request, capture and issue
module inst_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] inst_count
);

  // The PC is always word aligned, even if RESET_PC is not.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_inst;
  logic [31:0]  r_count;
  logic [31:0]  w_next_pc;
  logic         w_capture;
  logic         w_consume;

  pc_next u_pc_next (
    .pc           (r_pc),
    .jump         (jump),
    .jump_addr    (jump_addr),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .next_pc      (w_next_pc)
  );

  // Next-state: request until memory answers, then hold in ISSUE until consumed.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_consume   = 1'b0;
    case (r_state)
      FETCH, WAIT: begin
        if (imem_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      ISSUE: begin
        if (!stall) begin
          w_consume   = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  // State register; reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: capture on memory response, advance PC and count on consumption.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC_ALIGNED;
      r_inst  <= 32'd0;
      r_count <= 32'd0;
    end else begin
      if (w_capture) begin
        r_inst <= imem_rdata;
      end
      if (w_consume) begin
        r_pc    <= w_next_pc;
        r_count <= r_count + 32'd1;
      end
    end
  end

  assign imem_req   = (r_state != ISSUE);
  assign imem_addr  = r_pc;
  assign inst       = r_inst;
  assign inst_valid = (r_state == ISSUE);
  assign pc         = r_pc;
  assign inst_count = r_count;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard testbench for inst_fetch
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_imm = 16'd0;
  logic        jump = 1'b0;
  logic [25:0] jump_addr = 26'd0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] inst_count;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_addr    (jump_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .pc           (pc),
    .inst_count   (inst_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a_pc;
    logic [31:0] a_inst;
    logic [31:0] a_count;
  } issue_t;

  issue_t      sb_q[$];
  issue_t      mon_e;
  logic        mon_prev_valid = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_count;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Each newly issued instruction must match the oldest pending expectation.
  always @(negedge clk) begin
    if (inst_valid && !mon_prev_valid) begin
      check_eq("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check_eq("sb_pc", pc, mon_e.a_pc);
        check_eq("sb_inst", inst, mon_e.a_inst);
        check_eq("sb_count", inst_count, mon_e.a_count);
      end
    end
    mon_prev_valid <= inst_valid;
  end

  // One instruction: optional wait cycles, optional stall cycles, then consume
  // with the given redirect inputs; exp_next is the required next fetch address.
  task automatic fetch_issue(input int waits, input int stalls, input logic j,
                             input logic [25:0] ja, input logic b,
                             input logic [15:0] bi, input logic [31:0] exp_next);
    check_eq("fetch_req", 32'(imem_req), 32'd1);
    check_eq("fetch_addr", imem_addr, exp_pc);
    check_eq("fetch_valid", 32'(inst_valid), 32'd0);
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      stall      = 1'($urandom_range(0, 1));
      step();
      check_eq("wait_req", 32'(imem_req), 32'd1);
      check_eq("wait_addr", imem_addr, exp_pc);
      check_eq("wait_valid", 32'(inst_valid), 32'd0);
    end
    imem_ready = 1'b1;
    imem_rdata = mem_word(exp_pc);
    stall      = 1'($urandom_range(0, 1));
    sb_q.push_back('{a_pc: exp_pc, a_inst: mem_word(exp_pc), a_count: exp_count});
    step();
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    check_eq("issue_valid", 32'(inst_valid), 32'd1);
    check_eq("issue_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < stalls; i++) begin
      stall        = 1'b1;
      jump         = ~j;
      branch_taken = 1'b1;
      jump_addr    = 26'($urandom);
      branch_imm   = 16'($urandom);
      step();
      check_eq("stall_inst", inst, mem_word(exp_pc));
      check_eq("stall_pc", pc, exp_pc);
      check_eq("stall_count", inst_count, exp_count);
      check_eq("stall_req", 32'(imem_req), 32'd0);
      check_eq("stall_valid", 32'(inst_valid), 32'd1);
    end
    stall        = 1'b0;
    jump         = j;
    jump_addr    = ja;
    branch_taken = b;
    branch_imm   = bi;
    step();
    jump         = 1'b0;
    branch_taken = 1'b0;
    exp_pc       = exp_next;
    exp_count    = exp_count + 32'd1;
    check_eq("next_addr", imem_addr, exp_next);
    check_eq("post_count", inst_count, exp_count);
  endtask

  initial begin
    exp_pc    = 32'h0;
    exp_count = 32'h0;
    imem_ready = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    repeat (2) step();
    check_eq("rst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_inst", inst, 32'd0);
    check_eq("rst_count", inst_count, 32'd0);
    check_eq("rst_pc", pc, 32'd0);
    check_eq("rst_req", 32'(imem_req), 32'd1);
    imem_ready = 1'b0;
    rst_n      = 1'b1;

    fetch_issue(0, 0, 1'b0, 26'd0, 1'b0, 16'd0, 32'h0000_0004);
    fetch_issue(0, 0, 1'b0, 26'd0, 1'b0, 16'd0, 32'h0000_0008);
    fetch_issue(0, 0, 1'b0, 26'd0, 1'b0, 16'd0, 32'h0000_000C);
    check_eq("three_consumed", inst_count, 32'd3);
    fetch_issue(0, 0, 1'b0, 26'd0, 1'b0, 16'd0, 32'h0000_0010);
    fetch_issue(3, 0, 1'b0, 26'd0, 1'b0, 16'd0, 32'h0000_0014);
    fetch_issue(0, 5, 1'b0, 26'd0, 1'b0, 16'd0, 32'h0000_0018);
    fetch_issue(0, 0, 1'b0, 26'd0, 1'b0, 16'd0, 32'h0000_001C);
    fetch_issue(0, 0, 1'b0, 26'd0, 1'b0, 16'd0, 32'h0000_0020);
    fetch_issue(0, 0, 1'b0, 26'd0, 1'b1, 16'hFFFF, 32'h0000_0020);
    fetch_issue(0, 0, 1'b1, 26'h0000040, 1'b1, 16'hFFFF, 32'h0000_0100);
    fetch_issue(1, 0, 1'b0, 26'd0, 1'b1, 16'hFFBE, 32'hFFFF_FFFC);
    fetch_issue(0, 2, 1'b0, 26'd0, 1'b0, 16'd0, 32'h0000_0000);
    fetch_issue(0, 0, 1'b0, 26'd0, 1'b1, 16'h000E, 32'h0000_003C);
    fetch_issue(2, 0, 1'b0, 26'd0, 1'b0, 16'd0, 32'h0000_0040);
    fetch_issue(0, 0, 1'b1, 26'h3FFFFFF, 1'b0, 16'd0, 32'h0FFF_FFFC);
    fetch_issue(0, 0, 1'b0, 26'd0, 1'b0, 16'd0, 32'h1000_0000);
    fetch_issue(0, 1, 1'b1, 26'h0000010, 1'b0, 16'd0, 32'h1000_0040);

    // Sit in WAIT, then reset while a response arrives.
    check_eq("pre_rst_addr", imem_addr, 32'h1000_0040);
    imem_ready = 1'b0;
    repeat (2) step();
    check_eq("wait_before_rst", 32'(imem_req), 32'd1);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    rst_n      = 1'b0;
    #1;
    check_eq("async_rst_pc", pc, 32'd0);
    check_eq("async_rst_count", inst_count, 32'd0);
    check_eq("async_rst_inst", inst, 32'd0);
    check_eq("async_rst_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    repeat (2) step();
    imem_ready = 1'b0;
    rst_n      = 1'b1;
    exp_pc     = 32'h0;
    exp_count  = 32'h0;
    step();
    check_eq("post_rst_addr", imem_addr, 32'd0);
    check_eq("post_rst_count", inst_count, 32'd0);
    check_eq("post_rst_valid", 32'(inst_valid), 32'd0);
    fetch_issue(0, 0, 1'b0, 26'd0, 1'b0, 16'd0, 32'h0000_0004);
    step();
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
